// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive character FIFO with error tags, edge-triggered host pop,
//            registered read data and flow-control status flags.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Rx_Data,
    input  logic [2:0]           Rx_Err_In,
    input  logic                 Rx_Data_Rdy,
    input  logic                 Read_Done,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic [2:0]           Rx_Error,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow,
    output logic                 RTS
);

    localparam int               c_AW     = $clog2(FIFO_DEPTH);
    localparam int               c_EW     = DATA_BITS + 3;
    localparam logic [c_AW:0]    c_DEPTH  = FIFO_DEPTH[c_AW:0];
    localparam logic [c_AW:0]    c_HALF   = c_DEPTH >> 1;
    localparam logic [c_AW:0]    c_CNT1   = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]  c_PTR1   = c_AW'(1);

    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_rd_q;
    logic            r_lost;

    logic            w_at_depth;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;
    logic [c_AW:0]   w_count_nxt;
    logic            w_lost_nxt;
    logic            w_ovf_nxt;
    logic [c_EW-1:0] w_head;

    assign w_at_depth = (r_count == c_DEPTH);
    assign w_pop      = Read_Done & ~r_rd_q & (r_count != '0);
    // A pop in the same cycle frees a slot, so a write at full still lands.
    assign w_wr       = Rx_Data_Rdy & (~w_at_depth | w_pop);
    assign w_drop     = Rx_Data_Rdy & w_at_depth & ~w_pop;
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + c_CNT1;
        end else if (w_pop && !w_wr) begin
            w_count_nxt = r_count - c_CNT1;
        end
    end

    assign w_lost_nxt = w_pop ? 1'b0 : (r_lost | w_drop);
    assign w_ovf_nxt  = (w_count_nxt == c_DEPTH) | w_lost_nxt;

    // Storage is intentionally not reset.
    always_ff @(posedge Clk) begin
        if (Rst && w_wr) begin
            r_mem[r_wr_ptr] <= {Rx_Err_In, Rx_Data};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rd_q        <= 1'b0;
            r_lost        <= 1'b0;
            Data_Out      <= '0;
            Rx_Error      <= '0;
            FIFO_Empty    <= 1'b1;
            FIFO_Full     <= 1'b0;
            FIFO_Overflow <= 1'b0;
            RTS           <= 1'b1;
        end else begin
            r_rd_q <= Read_Done;
            r_lost <= w_lost_nxt;
            r_count <= w_count_nxt;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR1;
                Data_Out <= w_head[DATA_BITS-1:0];
                Rx_Error <= w_head[c_EW-1:DATA_BITS];
            end
            FIFO_Empty    <= (w_count_nxt == '0);
            FIFO_Full     <= (w_count_nxt > c_HALF);
            FIFO_Overflow <= w_ovf_nxt;
            RTS           <= ~w_ovf_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_DB    = 8;
    localparam int c_DEPTH = 8;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic [c_DB-1:0]   Rx_Data = '0;
    logic [2:0]        Rx_Err_In = '0;
    logic              Rx_Data_Rdy = 1'b0;
    logic              Read_Done = 1'b0;
    logic [c_DB-1:0]   Data_Out;
    logic [2:0]        Rx_Error;
    logic              FIFO_Empty;
    logic              FIFO_Full;
    logic              FIFO_Overflow;
    logic              RTS;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: contents as a plain queue of {err, data}.
    logic [c_DB+2:0] m_q[$];
    logic            m_lost = 1'b0;
    logic            m_rdq  = 1'b0;
    logic [c_DB-1:0] m_dout = '0;
    logic [2:0]      m_err  = '0;

    uart_rx_fifo #(.DATA_BITS(c_DB), .FIFO_DEPTH(c_DEPTH)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Rx_Data       (Rx_Data),
        .Rx_Err_In     (Rx_Err_In),
        .Rx_Data_Rdy   (Rx_Data_Rdy),
        .Read_Done     (Read_Done),
        .Data_Out      (Data_Out),
        .Rx_Error      (Rx_Error),
        .FIFO_Empty    (FIFO_Empty),
        .FIFO_Full     (FIFO_Full),
        .FIFO_Overflow (FIFO_Overflow),
        .RTS           (RTS)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic rdy, input logic [c_DB-1:0] d,
                              input logic [2:0] e, input logic rd);
        logic was_full;
        logic pop;
        logic [c_DB+2:0] ent;
        if (!rst_n) begin
            m_q.delete();
            m_lost = 1'b0;
            m_rdq  = 1'b0;
            m_dout = '0;
            m_err  = '0;
        end else begin
            was_full = (m_q.size() == c_DEPTH);
            pop = rd && !m_rdq && (m_q.size() != 0);
            if (pop) begin
                ent = m_q.pop_front();
                m_dout = ent[c_DB-1:0];
                m_err  = ent[c_DB+2:c_DB];
                m_lost = 1'b0;
            end
            if (rdy) begin
                if (!was_full || pop) m_q.push_back({e, d});
                else m_lost = 1'b1;
            end
            m_rdq = rd;
        end
    endtask

    task automatic step(input logic rst_n, input logic rdy, input logic [c_DB-1:0] d,
                        input logic [2:0] e, input logic rd);
        logic ovf;
        Rst = rst_n; Rx_Data_Rdy = rdy; Rx_Data = d; Rx_Err_In = e; Read_Done = rd;
        @(posedge Clk);
        model_edge(rst_n, rdy, d, e, rd);
        #1;
        ovf = (m_q.size() == c_DEPTH) || m_lost;
        chk("data_out", Data_Out, m_dout);
        chk("rx_error", Rx_Error, m_err);
        chk("empty",    FIFO_Empty, m_q.size() == 0);
        chk("full",     FIFO_Full, m_q.size() > c_DEPTH/2);
        chk("overflow", FIFO_Overflow, ovf);
        chk("rts",      RTS, !ovf);
    endtask

    task automatic wr(input logic [c_DB-1:0] d, input logic [2:0] e);
        step(1'b1, 1'b1, d, e, 1'b0);
    endtask

    task automatic pop1();
        step(1'b1, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [c_DB-1:0] rd_d;
        logic            r_rdy, r_rd, r_rst;
        logic [2:0]      rd_e;

        step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("rst_empty", FIFO_Empty, 1'b1);
        chk("rst_rts", RTS, 1'b1);

        // In-order delivery of a full buffer.
        for (int i = 0; i < 8; i++) wr(8'(i), 3'b000);
        for (int i = 0; i < 8; i++) pop1();
        chk("t1_last", Data_Out, 8'h07);
        chk("t1_empty", FIFO_Empty, 1'b1);

        // Half-full-plus-one threshold.
        for (int i = 0; i < 4; i++) wr(8'(8'h20 + i), 3'b000);
        chk("t2_full4", FIFO_Full, 1'b0);
        wr(8'h24, 3'b000);
        chk("t2_full5", FIFO_Full, 1'b1);
        chk("t2_ovf5", FIFO_Overflow, 1'b0);
        for (int i = 0; i < 5; i++) pop1();

        // Overflow and dropped character.
        for (int i = 0; i < 8; i++) wr(8'(i), 3'b000);
        chk("t3_ovf8", FIFO_Overflow, 1'b1);
        chk("t3_rts8", RTS, 1'b0);
        wr(8'hFF, 3'b000);
        chk("t3_ovf9", FIFO_Overflow, 1'b1);
        pop1();
        chk("t3_first", Data_Out, 8'h00);
        chk("t3_ovf_clr", FIFO_Overflow, 1'b0);
        for (int i = 0; i < 7; i++) pop1();
        chk("t3_last", Data_Out, 8'h07);

        // Write and pop together while full.
        for (int i = 0; i < 8; i++) wr(8'(8'h10 + i), 3'b000);
        step(1'b1, 1'b1, 8'hA5, 3'b000, 1'b1);
        chk("t4_head", Data_Out, 8'h10);
        chk("t4_still_full", FIFO_Overflow, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 8; i++) pop1();
        chk("t4_last", Data_Out, 8'hA5);

        // Error tag, held Read_Done, pop on empty.
        wr(8'hAA, 3'b010);
        pop1();
        chk("t5_data", Data_Out, 8'hAA);
        chk("t5_err", Rx_Error, 3'b010);
        wr(8'h31, 3'b000);
        wr(8'h32, 3'b000);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        chk("t5_hold", Data_Out, 8'h31);
        chk("t5_hold_ne", FIFO_Empty, 1'b0);
        pop1();
        pop1();
        chk("t5_emptypop", Data_Out, 8'h32);

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) wr(8'(8'h40 + i), 3'b001);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("t6_empty", FIFO_Empty, 1'b1);
        chk("t6_dout", Data_Out, 8'h00);
        chk("t6_rts", RTS, 1'b1);
        pop1();
        chk("t6_pop_ign", Data_Out, 8'h00);

        // Randomized traffic against the model.
        r_rd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rd_d  = 8'($urandom);
            rd_e  = 3'($urandom);
            r_rdy = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 99) < 45) r_rd = ~r_rd;
            r_rst = ($urandom_range(0, 299) != 0);
            step(r_rst, r_rdy, rd_d, rd_e, r_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
